// File: rtl/pwm_pkg.sv
// pwm_pkg: widths, PWM period and ramp state encoding shared by the PWM ramp sequencer.
package pwm_pkg;
    localparam int SPEED_W     = 3;
    localparam int PERIOD_BITS = 5;
    localparam int PWM_PERIOD  = 2 ** PERIOD_BITS;
    typedef enum logic [1:0] {OFF, HOLD, UP, DOWN} ramp_state_t;
endpackage

// File: rtl/pwm_phase_tracker.sv
// pwm_phase_tracker: mirrors the PWM counter phase and counts period ends while ramping.
module pwm_phase_tracker #(
    parameter int PERIOD_BITS  = pwm_pkg::PERIOD_BITS,
    parameter int STEP_PERIODS = 4
) (
    input  logic clock,
    input  logic reset_n,
    input  logic pwm_off,
    input  logic ramp_active,
    input  logic clear,
    output logic period_tick,
    output logic step_due
);
    localparam int CNT_W = STEP_PERIODS > 1 ? $clog2(STEP_PERIODS) : 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEP_PERIODS - 1);
    logic [PERIOD_BITS-1:0] phase;
    logic [CNT_W-1:0]       step_cnt;
    assign period_tick = !pwm_off && (&phase);
    assign step_due    = ramp_active && period_tick && step_cnt == LAST_STEP;
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) phase <= '0;
        else          phase <= pwm_off ? '0 : phase + PERIOD_BITS'(1);
    end
    // cleared outside a ramp so a partial first period from HOLD counts as a whole one
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)                             step_cnt <= '0;
        else if (clear || !ramp_active || step_due) step_cnt <= '0;
        else if (period_tick)                     step_cnt <= step_cnt + CNT_W'(1);
    end
endmodule

// File: rtl/pwm_ramp_ctrl.sv
// pwm_ramp_ctrl: soft-start/soft-stop sequencer stepping the PWM speed by one every
// STEP_PERIODS PWM periods toward a handshaked target; brake forces an immediate stop.
module pwm_ramp_ctrl #(
    parameter int SPEED_W      = pwm_pkg::SPEED_W,
    parameter int PERIOD_BITS  = pwm_pkg::PERIOD_BITS,
    parameter int STEP_PERIODS = 4
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [SPEED_W-1:0] cmd_speed,
    input  logic               brake,
    output logic [SPEED_W-1:0] speed,
    output logic               pwm_off,
    output logic               busy,
    output logic               at_target,
    output logic               period_tick
);
    import pwm_pkg::*;
    ramp_state_t        state, state_next;
    logic [SPEED_W-1:0] target, speed_inc, speed_dec;
    logic               accept, step_due;
    assign speed_inc = speed + SPEED_W'(1);
    assign speed_dec = speed - SPEED_W'(1);
    assign accept    = cmd_valid && cmd_ready;
    pwm_phase_tracker #(
        .PERIOD_BITS (PERIOD_BITS),
        .STEP_PERIODS(STEP_PERIODS)
    ) u_phase (
        .clock      (clock),
        .reset_n    (reset_n),
        .pwm_off    (pwm_off),
        .ramp_active(busy),
        .clear      (brake),
        .period_tick(period_tick),
        .step_due   (step_due)
    );
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= OFF;
        else          state <= state_next;
    end
    always_comb begin
        state_next = state;
        if (brake) state_next = OFF;
        else begin
            case (state)
                OFF:  if (accept && cmd_speed != '0) state_next = UP;
                HOLD: if (accept) state_next = cmd_speed > speed ? UP : cmd_speed < speed ? DOWN : HOLD;
                UP:   if (step_due && speed_inc == target) state_next = HOLD;
                DOWN: if (step_due && speed_dec == target) state_next = target == '0 ? OFF : HOLD;
                default: state_next = OFF;
            endcase
        end
    end
    always_comb begin
        busy      = state == UP || state == DOWN;
        at_target = !busy;
        cmd_ready = at_target && !brake;
    end
    // the PWM is held off exactly when the sequencer rests in OFF
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            speed   <= '0;
            target  <= '0;
            pwm_off <= 1'b1;
        end else begin
            pwm_off <= state_next == OFF;
            target  <= brake ? '0 : accept ? cmd_speed : target;
            speed   <= brake ? '0 :
                       (step_due && state == UP)   ? speed_inc :
                       (step_due && state == DOWN) ? speed_dec : speed;
        end
    end
endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// tb_pwm_ramp_ctrl: directed bench with a cycle model of the ramp rules and literal timing checks.
module tb_pwm_ramp_ctrl;
    localparam int STEP = 4;
    localparam int PER  = 32;
    logic       clock = 0, reset_n = 1, cmd_valid = 0, brake = 0;
    logic [2:0] cmd_speed = 0;
    logic       cmd_ready, pwm_off, busy, at_target, period_tick;
    logic [2:0] speed;
    int checks = 0, errors = 0;
    int m_speed = 0, m_target = 0, m_cyc = 0, m_per = 0;
    bit m_off = 1;
    int acc_speed;

    pwm_ramp_ctrl #(.STEP_PERIODS(STEP)) dut (
        .clock(clock), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_speed(cmd_speed), .brake(brake), .speed(speed), .pwm_off(pwm_off),
        .busy(busy), .at_target(at_target), .period_tick(period_tick)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // model: ramping means speed differs from target; it steps once per STEP whole periods
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_speed = 0; m_target = 0; m_off = 1; m_cyc = 0; m_per = 0;
        end else if (brake) begin
            m_speed = 0; m_target = 0; m_off = 1; m_cyc = 0; m_per = 0;
        end else begin
            bit tick;
            tick = !m_off && (m_cyc % PER == PER - 1);
            if (!m_off) m_cyc++;
            if (m_speed != m_target) begin
                if (tick) begin
                    m_per++;
                    if (m_per % STEP == 0) begin
                        m_speed += (m_target > m_speed) ? 1 : -1;
                        if (m_speed == m_target && m_target == 0) begin
                            m_off = 1; m_cyc = 0;
                        end
                    end
                end
            end else begin
                m_per = 0;
                if (cmd_valid) begin
                    m_target = int'(cmd_speed);
                    if (cmd_speed != 0) m_off = 0;
                end
            end
        end
    end

    always @(negedge clock) begin
        check("speed", int'(speed), m_speed);
        check("pwm_off", int'(pwm_off), int'(m_off));
        check("busy", int'(busy), int'(m_speed != m_target));
        check("at_target", int'(at_target), int'(m_speed == m_target));
        check("cmd_ready", int'(cmd_ready), int'(m_speed == m_target && !brake));
        check("period_tick", int'(period_tick), int'(!m_off && (m_cyc % PER == PER - 1)));
    end

    task automatic tick1();
        @(posedge clock); #1;
    endtask

    task automatic send(input int v, input int limit);
        cmd_speed = 3'(v);
        cmd_valid = 1;
        for (int i = 0; i < limit; i++) begin
            if (cmd_ready) begin
                acc_speed = int'(speed);
                tick1();
                cmd_valid = 0;
                return;
            end
            tick1();
        end
        check("send_timeout", int'(cmd_ready), 1);
        cmd_valid = 0;
    endtask

    task automatic wait_hold(input int limit);
        for (int i = 0; i < limit; i++) begin
            if (at_target) return;
            tick1();
        end
        check("hold_timeout", int'(at_target), 1);
    endtask

    task automatic wait_speed(input int v, input int limit);
        for (int i = 0; i < limit; i++) begin
            if (int'(speed) == v) return;
            tick1();
        end
        check("speed_timeout", int'(speed), v);
    endtask

    initial begin
        #1 reset_n = 0;
        repeat (3) tick1();
        check("rst_speed", int'(speed), 0);
        check("rst_pwm_off", int'(pwm_off), 1);
        check("rst_ready", int'(cmd_ready), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_at_target", int'(at_target), 1);
        check("rst_tick", int'(period_tick), 0);
        reset_n = 1;
        tick1();
        // soft start 0 -> 3 with exact step timing
        send(3, 10);
        check("start_pwm_off", int'(pwm_off), 0);
        check("start_ready", int'(cmd_ready), 0);
        for (int s = 1; s <= 3; s++) begin
            repeat (PER * STEP - 1) tick1();
            check("pre_step_speed", int'(speed), s - 1);
            check("pre_step_tick", int'(period_tick), 1);
            tick1();
            check("step_speed", int'(speed), s);
        end
        check("hold3_ready", int'(cmd_ready), 1);
        check("hold3_busy", int'(busy), 0);
        // ramp down to 1, then a same-speed command is a no-op
        send(1, 10);
        check("down_busy", int'(busy), 1);
        wait_hold(1000);
        check("hold1_speed", int'(speed), 1);
        send(1, 10);
        check("noop_at_target", int'(at_target), 1);
        check("noop_speed", int'(speed), 1);
        // up to 2, then stop: last step re-enters OFF
        send(2, 10);
        wait_hold(1000);
        check("hold2_speed", int'(speed), 2);
        send(0, 10);
        wait_speed(1, 1000);
        check("stop_mid_off", int'(pwm_off), 0);
        wait_hold(1000);
        check("stop_speed", int'(speed), 0);
        check("stop_pwm_off", int'(pwm_off), 1);
        repeat (40) tick1();
        check("stop_tick", int'(period_tick), 0);
        // brake during a ramp toward 6
        send(6, 10);
        wait_speed(2, 1000);
        brake = 1; cmd_valid = 1; cmd_speed = 3'd4;
        #1 check("brake_ready", int'(cmd_ready), 0);
        tick1();
        brake = 0;
        #1;
        check("brake_speed", int'(speed), 0);
        check("brake_pwm_off", int'(pwm_off), 1);
        check("brake_at_target", int'(at_target), 1);
        check("release_ready", int'(cmd_ready), 1);
        tick1();
        cmd_valid = 0;
        check("release_accept_off", int'(pwm_off), 0);
        check("release_accept_busy", int'(busy), 1);
        // a held command waits through the whole ramp toward 4
        send(5, 2000);
        check("held_accept_speed", acc_speed, 4);
        repeat (PER * STEP - 2) tick1();
        check("held_pre_speed", int'(speed), 4);
        tick1();
        check("held_up_speed", int'(speed), 5);
        // asynchronous reset in the middle of a ramp
        send(7, 10);
        repeat (50) tick1();
        #2 reset_n = 0;
        #1;
        check("async_speed", int'(speed), 0);
        check("async_pwm_off", int'(pwm_off), 1);
        check("async_ready", int'(cmd_ready), 1);
        check("async_busy", int'(busy), 0);
        check("async_at_target", int'(at_target), 1);
        check("async_tick", int'(period_tick), 0);
        repeat (2) tick1();
        reset_n = 1;
        repeat (4) tick1();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
